rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, the write-data width.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, the maximum number of consecutive ALU-denied cycles before ALU priority is forced; legal range 1..15.
REQ-003 SHALL have one clock and an asynchronous active-low reset: i_clk input 1 (rising-edge clock), then i_rst_n input 1 (asynchronous active-low reset).
REQ-004 SHALL have i_alu_valid input 1: ALU writeback request.
REQ-005 SHALL have i_alu_rd input 5 (ALU destination) and i_alu_data input XLEN (ALU result).
REQ-006 SHALL have o_alu_ready output 1: ALU request accepted this cycle.
REQ-007 SHALL have i_lsu_valid input 1, i_lsu_rd input 5 and i_lsu_data input XLEN: the load-return request, destination and data.
REQ-008 SHALL have o_lsu_ready output 1: LSU request accepted this cycle.
REQ-009 SHALL have o_rf_write_en output 1, o_rf_rd_addr output 5 and o_rf_rd_data output XLEN, which drive the register-file write port.
REQ-010 SHALL have i_iss_valid input 1 and i_iss_rd input 5: an instruction issued that will write i_iss_rd.
REQ-011 SHALL have o_busy output 32: per-register pending-write flags.

Function
REQ-012 SHALL accept a request only when valid and ready are both high in the same cycle; at most one request is accepted per cycle.
REQ-013 SHALL compute each ready combinationally from the valids and the arbitration state; ready never depends on the other requester's ready.
REQ-014 SHALL register the accepted request: o_rf_write_en, o_rf_rd_addr and o_rf_rd_data are valid one cycle after acceptance, with 1-cycle latency and a write pulse one cycle wide.
REQ-015 SHALL force o_rf_write_en to 0 for an accepted request with rd=0; the request is still accepted (ready=1) and dropped.
REQ-016 SHALL hold o_rf_write_en at 0 in any cycle with no acceptance, with address and data holding their last values.
REQ-017 SHALL implement arbitration as an FSM with two states:
  - PRI_LSU: LSU wins when both requesters are valid.
  - PRI_ALU: ALU wins when both requesters are valid.
REQ-018 SHALL maintain a starve counter: it increments on each cycle where the ALU is valid and the LSU is granted, and clears on an ALU grant or when the ALU is not valid.
REQ-019 SHALL move from PRI_LSU to PRI_ALU on the edge where the starve counter reaches STARVE_LIMIT.
REQ-020 SHALL move from PRI_ALU to PRI_LSU on the edge after an ALU grant, clearing the counter.
REQ-021 SHALL grant a single valid requester regardless of FSM state; the FSM state changes only per REQ-019/020.
REQ-022 SHALL size the starve counter at 4 bits and never let it wrap; it saturates at STARVE_LIMIT.

Reset
REQ-023 SHALL, on i_rst_n low, immediately drive all of the following:
  - o_rf_write_en, o_rf_rd_addr, o_rf_rd_data = 0.
  - o_busy = 0.
  - FSM = PRI_LSU, starve counter = 0.
REQ-024 SHALL drive o_alu_ready and o_lsu_ready to 0 while i_rst_n is low.
REQ-025 SHALL discard a request accepted in the cycle in which reset asserts; no write follows.

Configuration
REQ-026 SHALL compile in the scoreboard only when macro RF_WB_SCOREBOARD_EN is defined.
REQ-027 SHALL apply the following scoreboard rules when RF_WB_SCOREBOARD_EN is defined:
  - Issue with rd!=0 sets busy[rd] at the next edge.
  - A registered write (o_rf_write_en=1) clears busy[o_rf_rd_addr] at the next edge.
  - Simultaneous set and clear of the same register: set wins.
  - busy[0] is constant 0.
REQ-028 SHALL tie o_busy to 0 and ignore i_iss_valid/i_iss_rd when RF_WB_SCOREBOARD_EN is undefined; arbitration is unchanged.

Structure
REQ-029 SHALL take XLEN default, REG_ADDR_W=5, NUM_REGS=32 and the arbitration-state enum from shared package rf_pkg.
REQ-030 SHALL place the scoreboard in sub-module rf_scoreboard, instantiated only under RF_WB_SCOREBOARD_EN.

Verification
REQ-031 SHALL cover single ALU request: rd=5, data=0xDEADBEEF -> o_alu_ready=1 same cycle; next cycle o_rf_write_en=1, addr=5, data=0xDEADBEEF.
REQ-032 SHALL cover simultaneous requests: ALU rd=3 and LSU rd=4 in PRI_LSU -> LSU granted first, write to x4; ALU granted next cycle, write to x3.
REQ-033 SHALL cover starvation: STARVE_LIMIT=4, LSU and ALU valid continuously -> 4 LSU grants, then 1 ALU grant, then the LSU-first pattern repeats.
REQ-034 SHALL cover the rd=0 drop: LSU rd=0, data=0x1 -> o_lsu_ready=1, o_rf_write_en stays 0.
REQ-035 SHALL cover the scoreboard (RF_WB_SCOREBOARD_EN defined): issue rd=7 -> busy[7]=1; write x7 together with a new issue of rd=7 -> busy[7] stays 1.
REQ-036 SHALL cover asynchronous reset mid-operation: i_rst_n low during an accepted request -> outputs, o_busy and FSM reset immediately, and no write after release.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback arbiter and its scoreboard.
package rf_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int CNT_W      = 4;

    typedef enum logic {
        PRI_LSU = 1'b0,
        PRI_ALU = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-write flags: set by issue, cleared by a registered write.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_iss_valid,
    input  logic [REG_ADDR_W-1:0] i_iss_rd,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    output logic [NUM_REGS-1:0]   o_busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Set is applied after clear so a same-cycle reissue keeps the register pending.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (i_iss_valid && (i_iss_rd != '0)) begin
            set_mask[i_iss_rd] = 1'b1;
        end
        if (i_wr_en) begin
            clr_mask[i_wr_addr] = 1'b1;
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Two-requester (ALU/LSU) register-file writeback arbiter with starvation guard.
// Optional busy scoreboard compiled in with macro RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    output logic                  o_alu_ready,
    input  logic                  i_lsu_valid,
    input  logic [REG_ADDR_W-1:0] i_lsu_rd,
    input  logic [XLEN-1:0]       i_lsu_data,
    output logic                  o_lsu_ready,
    output logic                  o_rf_write_en,
    output logic [REG_ADDR_W-1:0] o_rf_rd_addr,
    output logic [XLEN-1:0]       o_rf_rd_data,
    input  logic                  i_iss_valid,
    input  logic [REG_ADDR_W-1:0] i_iss_rd,
    output logic [NUM_REGS-1:0]   o_busy,
    output arb_state_e            o_dbg_state
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Handshake: a request transfers in a cycle where its valid and ready are both
    // high; ready is a function of both valids and the priority state only.
    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wen_q, wen_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;

    logic                  alu_grant;
    logic                  lsu_grant;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (i_rst_n) begin
            alu_grant = i_alu_valid && (!i_lsu_valid || (state_q == PRI_ALU));
            lsu_grant = i_lsu_valid && (!i_alu_valid || (state_q == PRI_LSU));
        end
    end

    assign o_alu_ready = alu_grant;
    assign o_lsu_ready = lsu_grant;

    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (alu_grant || !i_alu_valid) begin
            cnt_d = '0;
        end else if (lsu_grant) begin
            cnt_d = (cnt_q >= LIMIT) ? LIMIT : cnt_q + 1'b1;
        end
        case (state_q)
            PRI_LSU: if (cnt_d == LIMIT) state_d = PRI_ALU;
            PRI_ALU: if (alu_grant)      state_d = PRI_LSU;
            default: state_d = PRI_LSU;
        endcase
    end

    // Writes to x0 are accepted but never reach the port; address/data hold.
    always_comb begin
        sel_rd   = lsu_grant ? i_lsu_rd   : i_alu_rd;
        sel_data = lsu_grant ? i_lsu_data : i_alu_data;
        wen_d    = (alu_grant || lsu_grant) && (sel_rd != '0);
        addr_d   = wen_d ? sel_rd   : addr_q;
        data_d   = wen_d ? sel_data : data_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= PRI_LSU;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign o_rf_write_en = wen_q;
    assign o_rf_rd_addr  = addr_q;
    assign o_rf_rd_data  = data_q;
    assign o_dbg_state   = state_q;

`ifdef RF_WB_SCOREBOARD_EN
    rf_scoreboard u_scoreboard (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_iss_valid (i_iss_valid),
        .i_iss_rd    (i_iss_rd),
        .i_wr_en     (wen_q),
        .i_wr_addr   (addr_q),
        .o_busy      (o_busy)
    );
`else
    logic unused_iss;
    assign unused_iss = ^{i_iss_valid, i_iss_rd};
    assign o_busy     = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (STARVE_LIMIT=4, XLEN=32).
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_alu_valid;
    logic [4:0]  i_alu_rd;
    logic [31:0] i_alu_data;
    logic        o_alu_ready;
    logic        i_lsu_valid;
    logic [4:0]  i_lsu_rd;
    logic [31:0] i_lsu_data;
    logic        o_lsu_ready;
    logic        o_rf_write_en;
    logic [4:0]  o_rf_rd_addr;
    logic [31:0] o_rf_rd_data;
    logic        i_iss_valid;
    logic [4:0]  i_iss_rd;
    logic [31:0] o_busy;
    arb_state_e  o_dbg_state;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(4)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_alu_valid   (i_alu_valid),
        .i_alu_rd      (i_alu_rd),
        .i_alu_data    (i_alu_data),
        .o_alu_ready   (o_alu_ready),
        .i_lsu_valid   (i_lsu_valid),
        .i_lsu_rd      (i_lsu_rd),
        .i_lsu_data    (i_lsu_data),
        .o_lsu_ready   (o_lsu_ready),
        .o_rf_write_en (o_rf_write_en),
        .o_rf_rd_addr  (o_rf_rd_addr),
        .o_rf_rd_data  (o_rf_rd_data),
        .i_iss_valid   (i_iss_valid),
        .i_iss_rd      (i_iss_rd),
        .o_busy        (o_busy),
        .o_dbg_state   (o_dbg_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_alu_valid = 1'b0;
        i_lsu_valid = 1'b0;
        i_iss_valid = 1'b0;
    endtask

    initial begin
        logic [9:0] exp_alu_win;
        logic [9:0] exp_pri_alu;
        exp_alu_win = 10'b10_0001_0000;
        exp_pri_alu = 10'b01_0000_1000;

        // Reset: requests held valid must not see ready.
        i_rst_n     = 1'b0;
        i_alu_valid = 1'b1;
        i_alu_rd    = 5'd1;
        i_alu_data  = 32'h1111_1111;
        i_lsu_valid = 1'b1;
        i_lsu_rd    = 5'd2;
        i_lsu_data  = 32'h2222_2222;
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd3;
        tick();
        tick();
        check("rst_alu_ready", 32'(o_alu_ready), 32'd0);
        check("rst_lsu_ready", 32'(o_lsu_ready), 32'd0);
        check("rst_wen", 32'(o_rf_write_en), 32'd0);
        check("rst_addr", 32'(o_rf_rd_addr), 32'd0);
        check("rst_data", o_rf_rd_data, 32'd0);
        check("rst_busy", o_busy, 32'd0);
        check("rst_state", 32'(o_dbg_state), 32'(PRI_LSU));
        idle();
        tick();
        i_rst_n = 1'b1;

        // Single ALU request.
        i_alu_valid = 1'b1;
        i_alu_rd    = 5'd5;
        i_alu_data  = 32'hDEAD_BEEF;
        #1;
        check("single_alu_ready", 32'(o_alu_ready), 32'd1);
        check("single_lsu_ready", 32'(o_lsu_ready), 32'd0);
        tick();
        idle();
        check("single_wen", 32'(o_rf_write_en), 32'd1);
        check("single_addr", 32'(o_rf_rd_addr), 32'd5);
        check("single_data", o_rf_rd_data, 32'hDEAD_BEEF);
        tick();
        check("idle_wen", 32'(o_rf_write_en), 32'd0);
        check("idle_addr_hold", 32'(o_rf_rd_addr), 32'd5);
        check("idle_data_hold", o_rf_rd_data, 32'hDEAD_BEEF);

        // Simultaneous requests in PRI_LSU: LSU first, then ALU.
        i_alu_valid = 1'b1;
        i_alu_rd    = 5'd3;
        i_alu_data  = 32'h0000_0033;
        i_lsu_valid = 1'b1;
        i_lsu_rd    = 5'd4;
        i_lsu_data  = 32'h0000_0044;
        #1;
        check("both_lsu_ready", 32'(o_lsu_ready), 32'd1);
        check("both_alu_ready", 32'(o_alu_ready), 32'd0);
        tick();
        i_lsu_valid = 1'b0;
        check("both_wr1_addr", 32'(o_rf_rd_addr), 32'd4);
        check("both_wr1_data", o_rf_rd_data, 32'h0000_0044);
        #1;
        check("both_alu_ready2", 32'(o_alu_ready), 32'd1);
        tick();
        idle();
        check("both_wr2_wen", 32'(o_rf_write_en), 32'd1);
        check("both_wr2_addr", 32'(o_rf_rd_addr), 32'd3);
        check("both_wr2_data", o_rf_rd_data, 32'h0000_0033);

        // Starvation: both valid continuously.
        i_alu_valid = 1'b1;
        i_alu_rd    = 5'd10;
        i_alu_data  = 32'hA1A1_A1A1;
        i_lsu_valid = 1'b1;
        i_lsu_rd    = 5'd11;
        i_lsu_data  = 32'h5B5B_5B5B;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("starve_alu_ready_%0d", i), 32'(o_alu_ready), 32'(exp_alu_win[i]));
            check($sformatf("starve_lsu_ready_%0d", i), 32'(o_lsu_ready), 32'(!exp_alu_win[i]));
            tick();
            check($sformatf("starve_addr_%0d", i), 32'(o_rf_rd_addr),
                  exp_alu_win[i] ? 32'd10 : 32'd11);
            check($sformatf("starve_state_%0d", i), 32'(o_dbg_state),
                  exp_pri_alu[i] ? 32'(PRI_ALU) : 32'(PRI_LSU));
        end
        idle();

        // rd=0 accepted but dropped.
        i_lsu_valid = 1'b1;
        i_lsu_rd    = 5'd0;
        i_lsu_data  = 32'h0000_0001;
        #1;
        check("rd0_lsu_ready", 32'(o_lsu_ready), 32'd1);
        tick();
        idle();
        check("rd0_wen", 32'(o_rf_write_en), 32'd0);

        // Scoreboard: issue x7, then write x7 alongside a reissue of x7.
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd7;
        tick();
        idle();
`ifdef RF_WB_SCOREBOARD_EN
        check("sb_set7", o_busy, 32'h0000_0080);
`else
        check("sb_off_busy", o_busy, 32'd0);
`endif
        i_alu_valid = 1'b1;
        i_alu_rd    = 5'd7;
        i_alu_data  = 32'h0000_0077;
        tick();
        idle();
        check("sb_wr7_wen", 32'(o_rf_write_en), 32'd1);
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd7;
        tick();
        idle();
`ifdef RF_WB_SCOREBOARD_EN
        check("sb_set_wins", o_busy, 32'h0000_0080);
`else
        check("sb_off_busy2", o_busy, 32'd0);
`endif
        i_iss_valid = 1'b1;
        i_iss_rd    = 5'd9;
        tick();
        i_iss_rd    = 5'd0;
        i_alu_valid = 1'b1;
        i_alu_rd    = 5'd9;
        i_alu_data  = 32'h0000_0099;
        tick();
        idle();
        tick();
`ifdef RF_WB_SCOREBOARD_EN
        check("sb_clr9_keep7", o_busy, 32'h0000_0080);
`else
        check("sb_off_busy3", o_busy, 32'd0);
`endif

        // Reach PRI_ALU, then assert reset during an accepted ALU request.
        i_alu_valid = 1'b1;
        i_alu_rd    = 5'd12;
        i_alu_data  = 32'h0000_CAFE;
        i_lsu_valid = 1'b1;
        i_lsu_rd    = 5'd13;
        i_lsu_data  = 32'h0000_D00D;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_state", 32'(o_dbg_state), 32'(PRI_ALU));
        check("pre_rst_wen", 32'(o_rf_write_en), 32'd1);
        #1;
        check("pre_rst_alu_ready", 32'(o_alu_ready), 32'd1);
        #1;
        i_rst_n = 1'b0;
        #1;
        check("async_wen", 32'(o_rf_write_en), 32'd0);
        check("async_addr", 32'(o_rf_rd_addr), 32'd0);
        check("async_data", o_rf_rd_data, 32'd0);
        check("async_busy", o_busy, 32'd0);
        check("async_state", 32'(o_dbg_state), 32'(PRI_LSU));
        check("async_alu_ready", 32'(o_alu_ready), 32'd0);
        tick();
        idle();
        check("in_rst_wen", 32'(o_rf_write_en), 32'd0);
        i_rst_n = 1'b1;
        tick();
        check("post_rst_wen", 32'(o_rf_write_en), 32'd0);
        check("post_rst_addr", 32'(o_rf_rd_addr), 32'd0);
        check("post_rst_state", 32'(o_dbg_state), 32'(PRI_LSU));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
